// File: rtl/merge_rr_sequencer.sv
// Round-robin arbiter and sequencer for a merge stage. It grants one 4-phase requester at a time,
// drives its 1-based index on sel and forwards its word on a single 4-phase output channel.
module merge_rr_sequencer #(
    parameter int WIDTH  = 8,
    parameter int N      = 2,
    parameter int FL_CYC = 2,
    parameter int BL_CYC = 4,
    localparam int SW    = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_req,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ack,
    output logic                 out_req,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ack,
    output logic [SW-1:0]        sel,
    output logic                 busy
);

    localparam int CMAX = (FL_CYC > BL_CYC) ? FL_CYC : BL_CYC;
    localparam int CW   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;
    localparam int PW   = $clog2(N);

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        OUT_REQ,
        RTZ,
        BACK
    } state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant;
    logic [CW-1:0] cnt;
    logic [PW-1:0] pick;
    logic          found;

    // First requester at or after rr_ptr, scanning with wrap-around.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && in_req[(int'(rr_ptr) + k) % N]) begin
                pick  = PW'((int'(rr_ptr) + k) % N);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            cnt      <= '0;
            in_ack   <= '0;
            out_req  <= 1'b0;
            out_data <= '0;
            sel      <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= pick;
                        out_data <= in_data[int'(pick)*WIDTH +: WIDTH];
                        sel      <= SW'(int'(pick) + 1);
                        rr_ptr   <= (int'(pick) == N - 1) ? '0 : pick + 1'b1;
                        busy     <= 1'b1;
                        if (FL_CYC == 0) begin
                            out_req <= 1'b1;
                            state   <= OUT_REQ;
                        end else begin
                            cnt   <= CW'(FL_CYC - 1);
                            state <= FWD;
                        end
                    end
                end
                FWD: begin
                    if (cnt == '0) begin
                        out_req <= 1'b1;
                        state   <= OUT_REQ;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                OUT_REQ: begin
                    if (out_ack) begin
                        out_req <= 1'b0;
                        in_ack  <= N'(1) << grant;
                        state   <= RTZ;
                    end
                end
                RTZ: begin
                    // A requester that withdrew early still lets the channel return to zero.
                    if (!out_ack && !in_req[grant]) begin
                        in_ack <= '0;
                        sel    <= '0;
                        if (BL_CYC == 0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt   <= CW'(BL_CYC - 1);
                            state <= BACK;
                        end
                    end
                end
                BACK: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_merge_rr_sequencer.sv
// Bench for merge_rr_sequencer: directed handshake scenarios on two configurations, then
// randomized 4-phase traffic checked against a transaction-level model of the merge rules.
module tb_merge_rr_sequencer;

    localparam int W = 8;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_req;
    logic [N*W-1:0] in_data;
    logic           out_ack;

    logic [N-1:0] in_ack_a, in_ack_b;
    logic         out_req_a, out_req_b;
    logic [W-1:0] out_data_a, out_data_b;
    logic [1:0]   sel_a, sel_b;
    logic         busy_a, busy_b;

    always #5 clk = ~clk;

    merge_rr_sequencer #(.WIDTH(W), .N(N), .FL_CYC(2), .BL_CYC(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_data(in_data), .in_ack(in_ack_a),
        .out_req(out_req_a), .out_data(out_data_a), .out_ack(out_ack), .sel(sel_a), .busy(busy_a)
    );

    merge_rr_sequencer #(.WIDTH(W), .N(N), .FL_CYC(0), .BL_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_data(in_data), .in_ack(in_ack_b),
        .out_req(out_req_b), .out_data(out_data_b), .out_ack(out_ack), .sel(sel_b), .busy(busy_b)
    );

    // Observed outputs of whichever instance the environment is currently serving.
    logic         tgt = 1'b0;
    logic [N-1:0] o_in_ack;
    logic         o_out_req;
    logic [W-1:0] o_out_data;
    logic [1:0]   o_sel;
    logic         o_busy;

    always_comb begin
        o_in_ack   = tgt ? in_ack_b   : in_ack_a;
        o_out_req  = tgt ? out_req_b  : out_req_a;
        o_out_data = tgt ? out_data_b : out_data_a;
        o_sel      = tgt ? sel_b      : sel_a;
        o_busy     = tgt ? busy_b     : busy_a;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: phase 0 idle/backoff, 1 forwarding, 2 output request, 3 return-to-zero.
    int           fl, bl;
    int           ptr, phase, age, cur, back_left, cyc;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_words[$];
    int           grant_cyc[$];
    int           p_req, p_ack;
    bit           fixed_data;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        in_req  = '0;
        in_data = '0;
        out_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        ptr       = 0;
        phase     = 0;
        age       = 0;
        cur       = 0;
        back_left = 0;
        exp_q.delete();
        got_words.delete();
        grant_cyc.delete();
    endtask

    // Inputs still hold the values that the preceding rising edge sampled.
    task automatic observe();
        int w;
        case (phase)
            0: begin
                if (back_left > 0) begin
                    back_left--;
                    chk("back_sel", o_sel, 0);
                    chk("back_busy", o_busy, back_left != 0);
                    chk("back_oreq", o_out_req, 0);
                end else if (in_req != '0) begin
                    w = rr_pick(in_req, ptr);
                    chk("grant_sel", o_sel, w + 1);
                    chk("grant_data", o_out_data, in_data[w*W +: W]);
                    chk("grant_busy", o_busy, 1);
                    chk("grant_oreq", o_out_req, fl == 0);
                    exp_q.push_back(in_data[w*W +: W]);
                    grant_cyc.push_back(cyc);
                    ptr   = (w + 1) % N;
                    cur   = w;
                    age   = 0;
                    phase = (fl == 0) ? 2 : 1;
                end else begin
                    chk("idle_sel", o_sel, 0);
                    chk("idle_busy", o_busy, 0);
                    chk("idle_oreq", o_out_req, 0);
                end
            end
            1: begin
                age++;
                chk("fwd_sel", o_sel, cur + 1);
                chk("fwd_inack", o_in_ack, 0);
                chk("fwd_oreq", o_out_req, age >= fl);
                if (age >= fl) phase = 2;
            end
            2: begin
                if (out_ack) begin
                    chk("hs_oreq", o_out_req, 0);
                    chk("hs_inack", o_in_ack, 1 << cur);
                    chk("hs_data", o_out_data, exp_q[0]);
                    got_words.push_back(exp_q.pop_front());
                    phase = 3;
                end else begin
                    chk("out_oreq", o_out_req, 1);
                    chk("out_data", o_out_data, exp_q[0]);
                    chk("out_inack", o_in_ack, 0);
                    chk("out_sel", o_sel, cur + 1);
                end
            end
            default: begin
                if (!out_ack && !in_req[cur]) begin
                    chk("rtz_inack", o_in_ack, 0);
                    chk("rtz_sel", o_sel, 0);
                    chk("rtz_busy", o_busy, bl != 0);
                    back_left = bl;
                    phase     = 0;
                end else begin
                    chk("rtz_hold", o_in_ack, 1 << cur);
                    chk("rtz_sel_hold", o_sel, cur + 1);
                end
            end
        endcase
    endtask

    task automatic env_drive();
        for (int i = 0; i < N; i++) begin
            if (in_req[i] && o_in_ack[i]) begin
                if ($urandom_range(99) < p_req) in_req[i] = 1'b0;
            end else if (!in_req[i] && !o_in_ack[i]) begin
                if ($urandom_range(99) < p_req) begin
                    in_req[i] = 1'b1;
                    if (!fixed_data) in_data[i*W +: W] = W'($urandom);
                end
            end
        end
        if (o_out_req && !out_ack) begin
            if ($urandom_range(99) < p_ack) out_ack = 1'b1;
        end else if (!o_out_req && out_ack) begin
            if ($urandom_range(99) < p_ack) out_ack = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        observe();
        env_drive();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before the sequence finished");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        fixed_data = 1'b0;
        p_req = 100;
        p_ack = 100;
        tgt = 1'b0;
        fl = 2;
        bl = 4;

        // Reset values and a single requester.
        do_reset();
        chk("rst_sel", sel_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_oreq", out_req_a, 0);
        chk("rst_inack", in_ack_a, 0);
        chk("rst_data", out_data_a, 0);
        in_req  = 2'b01;
        in_data = 16'h00A5;
        @(negedge clk);
        chk("t2_sel", sel_a, 1);
        chk("t2_data", out_data_a, 8'hA5);
        chk("t2_oreq_e0", out_req_a, 0);
        chk("t2_busy", busy_a, 1);
        @(negedge clk);
        chk("t2_oreq_e1", out_req_a, 0);
        @(negedge clk);
        chk("t2_oreq_e2", out_req_a, 1);
        out_ack = 1'b1;
        @(negedge clk);
        chk("t2_inack", in_ack_a, 2'b01);
        chk("t2_oreq_low", out_req_a, 0);
        in_req  = 2'b00;
        out_ack = 1'b0;
        @(negedge clk);
        chk("t2_rtz_inack", in_ack_a, 0);
        chk("t2_rtz_sel", sel_a, 0);
        chk("t2_back_busy0", busy_a, 1);
        repeat (3) @(negedge clk);
        chk("t2_back_busy3", busy_a, 1);
        @(negedge clk);
        chk("t2_idle_busy", busy_a, 0);

        // Slow consumer: requester 0 wins again by wrap-around, out_ack withheld.
        in_req  = 2'b01;
        in_data = 16'h4477;
        @(negedge clk);
        chk("t4_sel", sel_a, 1);
        for (int k = 0; k < 20 && !out_req_a; k++) @(negedge clk);
        chk("t4_oreq_up", out_req_a, 1);
        in_req = 2'b11;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_oreq_hold", out_req_a, 1);
            chk("t4_data_hold", out_data_a, 8'h77);
            chk("t4_inack_hold", in_ack_a, 0);
            chk("t4_sel_hold", sel_a, 1);
        end

        // Asynchronous reset in the middle of the output request.
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_oreq", out_req_a, 0);
        chk("t1_inack", in_ack_a, 0);
        chk("t1_sel", sel_a, 0);
        chk("t1_busy", busy_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_first_grant", sel_a, 1);
        chk("t1_first_data", out_data_a, 8'h77);

        // Request withdrawn one cycle after its grant.
        do_reset();
        in_req  = 2'b01;
        in_data = 16'h005C;
        @(negedge clk);
        chk("t5_sel", sel_a, 1);
        in_req = 2'b00;
        for (int k = 0; k < 20 && !out_req_a; k++) @(negedge clk);
        chk("t5_oreq_up", out_req_a, 1);
        out_ack = 1'b1;
        @(negedge clk);
        chk("t5_inack", in_ack_a, 2'b01);
        chk("t5_data", out_data_a, 8'h5C);
        out_ack = 1'b0;
        @(negedge clk);
        chk("t5_inack_low", in_ack_a, 0);
        chk("t5_sel_low", sel_a, 0);
        repeat (3) @(negedge clk);
        chk("t5_back_busy", busy_a, 1);
        @(negedge clk);
        chk("t5_idle_busy", busy_a, 0);
        chk("t5_no_regrant", sel_a, 0);

        // Alternation with both requesters always re-requesting and instant acks.
        do_reset();
        fixed_data = 1'b1;
        in_data    = 16'h3C5A;
        for (int k = 0; k < 200 && got_words.size() < 4; k++) cycle();
        chk("t3_count", got_words.size() >= 4, 1);
        if (got_words.size() >= 4) begin
            chk("t3_word0", got_words[0], 8'h5A);
            chk("t3_word1", got_words[1], 8'h3C);
            chk("t3_word2", got_words[2], 8'h5A);
            chk("t3_word3", got_words[3], 8'h3C);
        end

        // Zero latency configuration: one transaction every three cycles.
        tgt = 1'b1;
        fl  = 0;
        bl  = 0;
        do_reset();
        for (int k = 0; k < 100 && grant_cyc.size() < 5; k++) cycle();
        chk("t6_count", grant_cyc.size() >= 5, 1);
        for (int k = 1; k < grant_cyc.size(); k++) begin
            chk("t6_period", grant_cyc[k] - grant_cyc[k-1], 3);
        end

        // Randomized traffic on both configurations.
        fixed_data = 1'b0;
        p_req = 30;
        p_ack = 40;
        tgt = 1'b0;
        fl  = 2;
        bl  = 4;
        do_reset();
        for (int k = 0; k < 800; k++) cycle();
        chk("rand_a_progress", got_words.size() > 10, 1);
        tgt = 1'b1;
        fl  = 0;
        bl  = 0;
        do_reset();
        for (int k = 0; k < 600; k++) cycle();
        chk("rand_b_progress", got_words.size() > 10, 1);
        chk("rand_b_pending", exp_q.size() <= 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
